wb_scoreboard: RTL and testbench
================================

Name: wb_scoreboard

Overview:
- Write-side companion of the integer register file.
- Tracks which destination registers have writes in flight (busy bits), stalls issue on RAW and WAW hazards, and merges two completion sources onto the single register-file write port (WE3/A3/WD3):
  - ALU path: single-cycle, no backpressure.
  - LSU path: variable latency, valid/ready handshake.
- Sits between the decode/issue logic and the register file.

Parameters:
- XLEN, 32, data width of write-back values.
- LSU_DEPTH, 2, depth of the LSU completion buffer; must be a power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- iss_valid  in  1  decode presents an instruction
- iss_rd  in  5  destination register
- iss_rs1  in  5  source 1
- iss_rs2  in  5  source 2
- iss_wr  in  1  instruction writes rd
- iss_stall  out  1  issue blocked (combinational)
- a_valid  in  1  ALU completion
- a_rd  in  5  ALU destination
- a_data  in  XLEN  ALU result
- l_valid  in  1  LSU completion offered
- l_ready  out  1  LSU completion accepted
- l_rd  in  5  LSU destination
- l_data  in  XLEN  LSU load data
- we3  out  1  register file write enable
- a3  out  5  register file write address
- wd3  out  XLEN  register file write data
- busy  out  32  busy vector; bit 0 is constant 0
- err_spurious  out  1  sticky: completion received for a non-busy, nonzero rd

Behaviour:
- Reset (rst=0, asynchronous):
  - busy=0, we3=0, a3=0, wd3=0, err_spurious=0.
  - LSU buffer emptied.
  - l_ready=1 once reset is released.
  - Any in-flight completions are dropped.
- Stall logic (combinational): iss_stall = iss_valid && (busy[iss_rs1] || busy[iss_rs2] || (iss_wr && busy[iss_rd])).
  - busy[0] is always 0, so x0 never stalls.
- Issue acceptance: an issue is accepted when iss_valid && !iss_stall.
  - If iss_wr and iss_rd!=0, busy[iss_rd] is set at the next clk edge.
  - iss_rd=0 sets nothing.
- LSU buffer: FIFO of LSU_DEPTH entries holding {rd, data}.
  - l_ready = buffer not full.
  - Push on l_valid && l_ready.
  - A push into an empty buffer is not eligible for write-out until the following cycle (registered).
- Write-out arbitration, evaluated each cycle:
  - If a_valid, the ALU completion wins and the LSU buffer holds.
  - Otherwise, if the buffer is non-empty, the head entry is popped.
  - A selected write appears on we3/a3/wd3 at the next edge (1-cycle latency). we3 is high for exactly one cycle per write; otherwise we3=0 and a3/wd3 hold their last values.
- Completions with rd=0 are dropped: no we3 pulse and no error. They still consume their arbitration slot.
- Busy clear:
  - busy[a3] is cleared at the edge following the we3 pulse, i.e. the same edge on which the register file captures WD3.
  - A dependent instruction therefore unstalls only once the register file already holds the value. No bypass is required.
- Spurious completion: a completion is spurious when it is selected with rd!=0 and busy[rd]=0 at selection time.
  - It is still written.
  - err_spurious is set and held until reset.
- Simultaneous events:
  - An issue to rd while rd is being cleared in the same cycle stalls, because busy is still 1 that cycle.
  - A set and a clear of different bits in the same cycle are both applied.
  - A push and a pop in the same cycle with the buffer full is not possible, because l_ready=0 when full.
- Throughput:
  - One register-file write per cycle.
  - A continuous a_valid stream starves the LSU. This is accepted, since the ALU issues only when decode is not stalled.

Test Plan:
- Issue rd=5 (iss_wr=1), ALU completes rd=5 data 0x1234 two cycles later:
  - we3=1, a3=5, wd3=0x00001234 one cycle after a_valid.
  - busy[5] falls on the next edge.
  - An issue reading rs1=5 stalls until then, then proceeds.
- Issue rd=0 followed by an ALU completion to x0: busy stays 0, no we3 pulse, err_spurious=0.
- Issue rd=7 and rd=8 (LSU). Present l_valid for rd=7 (0xAAAA) and rd=8 (0xBBBB) back-to-back while a_valid is held high for 3 cycles:
  - l_ready drops after the 2nd push.
  - ALU writes come out first, then 7, then 8, in order, with the correct data.
- ALU and LSU complete in the same cycle (ALU rd=3, buffered LSU rd=4): the rd=3 write occurs first, the rd=4 write one cycle later, and both busy bits clear.
- Completion to non-busy rd=9: the write occurs and err_spurious=1, held until reset.
- Assert rst mid-operation (busy=0x00000180, buffer holding 1 entry):
  - busy=0, we3=0 immediately (asynchronously).
  - l_ready=1 once reset is released.
  - The buffered entry is never written.

Source files
------------

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: write-side scoreboard for the integer register file.
// Tracks in-flight destination registers, stalls issue on RAW/WAW hazards and
// merges the ALU (no backpressure) and LSU (valid/ready) completions onto the
// single register-file write port.
//   clk, rst           clock, asynchronous active-low reset
//   iss_*              issue request from decode; iss_stall blocks it (combinational)
//   a_valid/a_rd/a_data ALU completion, always accepted
//   l_valid/l_ready/l_rd/l_data LSU completion handshake into a small FIFO
//   we3/a3/wd3         register-file write port (registered, 1-cycle latency)
//   busy               in-flight destination vector, bit 0 always 0
//   err_spurious       sticky flag: completion written to a non-busy register
module wb_scoreboard #(
    parameter int XLEN      = 32,
    parameter int LSU_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      iss_rs1,
    input  logic [4:0]      iss_rs2,
    input  logic            iss_wr,
    output logic            iss_stall,
    input  logic            a_valid,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            l_valid,
    output logic            l_ready,
    input  logic [4:0]      l_rd,
    input  logic [XLEN-1:0] l_data,
    output logic            we3,
    output logic [4:0]      a3,
    output logic [XLEN-1:0] wd3,
    output logic [31:0]     busy,
    output logic            err_spurious
);
    localparam int AW = $clog2(LSU_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(LSU_DEPTH);

    logic [31:0]      busy_q, busy_d;
    logic             we3_q, we3_d;
    logic [4:0]       a3_q, a3_d;
    logic [XLEN-1:0]  wd3_q, wd3_d;
    logic             err_q, err_d;
    logic [XLEN+4:0]  mem_q [LSU_DEPTH];
    logic [XLEN+4:0]  mem_d [LSU_DEPTH];
    logic [AW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push, pop, sel_v;
    logic [4:0]       sel_rd;
    logic [XLEN-1:0]  sel_data;
    logic [XLEN+4:0]  head;

    assign iss_stall    = iss_valid && (busy_q[iss_rs1] || busy_q[iss_rs2] || (iss_wr && busy_q[iss_rd]));
    assign l_ready      = cnt_q != FULL;
    assign we3          = we3_q;
    assign a3           = a3_q;
    assign wd3          = wd3_q;
    assign busy         = busy_q;
    assign err_spurious = err_q;

    always_comb begin
        push     = l_valid && l_ready;
        // cnt_q is registered, so a fresh push is only visible to the pop side next cycle
        pop      = !a_valid && cnt_q != '0;
        head     = mem_q[rptr_q];
        sel_v    = a_valid || pop;
        sel_rd   = a_valid ? a_rd : head[XLEN+4:XLEN];
        sel_data = a_valid ? a_data : head[XLEN-1:0];
        mem_d    = mem_q;
        if (push) mem_d[wptr_q] = {l_rd, l_data};
        wptr_d   = wptr_q + AW'(push);
        rptr_d   = rptr_q + AW'(pop);
        cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        // x0 completions take their slot but never reach the write port
        we3_d    = sel_v && sel_rd != 5'd0;
        a3_d     = we3_d ? sel_rd : a3_q;
        wd3_d    = we3_d ? sel_data : wd3_q;
        err_d    = err_q || (we3_d && !busy_q[sel_rd]);
        busy_d   = busy_q;
        // clear lands on the same edge the register file captures wd3
        if (we3_q) busy_d[a3_q] = 1'b0;
        if (iss_valid && !iss_stall && iss_wr) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            we3_q  <= 1'b0;
            a3_q   <= '0;
            wd3_q  <= '0;
            err_q  <= 1'b0;
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < LSU_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            busy_q <= busy_d;
            we3_q  <= we3_d;
            a3_q   <= a3_d;
            wd3_q  <= wd3_d;
            err_q  <= err_d;
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            mem_q  <= mem_d;
        end
    end
endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard: table-driven directed bench for wb_scoreboard plus a
// hand-written mid-operation reset sequence.
module tb_wb_scoreboard;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iss_valid, iss_wr, iss_stall;
    logic [4:0]  iss_rd, iss_rs1, iss_rs2;
    logic        a_valid, l_valid, l_ready, we3, err_spurious;
    logic [4:0]  a_rd, l_rd, a3;
    logic [31:0] a_data, l_data, wd3, busy;
    int          n_chk = 0;
    int          n_fail = 0;

    wb_scoreboard #(.XLEN(32), .LSU_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_wr(iss_wr), .iss_stall(iss_stall),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
        .l_valid(l_valid), .l_ready(l_ready), .l_rd(l_rd), .l_data(l_data),
        .we3(we3), .a3(a3), .wd3(wd3), .busy(busy), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  ird, irs1, irs2;
        logic        iwr, av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        e_stall, e_lready, e_we3;
        logic [4:0]  e_a3;
        logic [31:0] e_wd3, e_busy;
        logic        e_err;
    } vec_t;

    vec_t tv [32];

    function automatic vec_t mk(logic iv, logic [4:0] ird, logic [4:0] irs1, logic [4:0] irs2, logic iwr,
                                logic av, logic [4:0] ard, logic [31:0] ad,
                                logic lv, logic [4:0] lrd, logic [31:0] ld,
                                logic st, logic lr, logic we, logic [4:0] ea3, logic [31:0] ewd,
                                logic [31:0] eb, logic er);
        vec_t v;
        v.iv = iv; v.ird = ird; v.irs1 = irs1; v.irs2 = irs2; v.iwr = iwr;
        v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.e_stall = st; v.e_lready = lr; v.e_we3 = we; v.e_a3 = ea3; v.e_wd3 = ewd;
        v.e_busy = eb; v.e_err = er;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        iss_valid = v.iv; iss_rd = v.ird; iss_rs1 = v.irs1; iss_rs2 = v.irs2; iss_wr = v.iwr;
        a_valid = v.av; a_rd = v.ard; a_data = v.ad;
        l_valid = v.lv; l_rd = v.lrd; l_data = v.ld;
    endtask

    task automatic idle();
        drive(mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,0));
    endtask

    task automatic check_outputs(input vec_t v, input int i);
        chk("iss_stall", i, 32'(iss_stall), 32'(v.e_stall));
        chk("l_ready", i, 32'(l_ready), 32'(v.e_lready));
        chk("we3", i, 32'(we3), 32'(v.e_we3));
        chk("a3", i, 32'(a3), 32'(v.e_a3));
        chk("wd3", i, wd3, v.e_wd3);
        chk("busy", i, busy, v.e_busy);
        chk("err_spurious", i, 32'(err_spurious), 32'(v.e_err));
    endtask

    initial begin
        //           iv rd r1 r2 wr  av rd data      lv rd data       st lr we a3 wd3       busy     err
        tv[0]  = mk(1, 5, 1, 2, 1,  0, 0, 0,        0, 0, 0,         0, 1, 0, 0, 0,        0,       0);
        tv[1]  = mk(1, 6, 5, 0, 1,  0, 0, 0,        0, 0, 0,         1, 1, 0, 0, 0,        'h20,    0);
        tv[2]  = mk(1, 6, 5, 0, 1,  1, 5, 'h1234,   0, 0, 0,         1, 1, 0, 0, 0,        'h20,    0);
        tv[3]  = mk(1, 6, 5, 0, 1,  0, 0, 0,        0, 0, 0,         1, 1, 1, 5, 'h1234,   'h20,    0);
        tv[4]  = mk(1, 6, 5, 0, 1,  0, 0, 0,        0, 0, 0,         0, 1, 0, 5, 'h1234,   0,       0);
        tv[5]  = mk(0, 0, 0, 0, 0,  1, 6, 'h66,     0, 0, 0,         0, 1, 0, 5, 'h1234,   'h40,    0);
        tv[6]  = mk(0, 0, 0, 0, 0,  0, 0, 0,        0, 0, 0,         0, 1, 1, 6, 'h66,     'h40,    0);
        tv[7]  = mk(1, 0, 0, 0, 1,  0, 0, 0,        0, 0, 0,         0, 1, 0, 6, 'h66,     0,       0);
        tv[8]  = mk(0, 0, 0, 0, 0,  1, 0, 'hDEAD,   0, 0, 0,         0, 1, 0, 6, 'h66,     0,       0);
        tv[9]  = mk(0, 0, 0, 0, 0,  0, 0, 0,        0, 0, 0,         0, 1, 0, 6, 'h66,     0,       0);
        tv[10] = mk(1, 7, 0, 0, 1,  0, 0, 0,        0, 0, 0,         0, 1, 0, 6, 'h66,     0,       0);
        tv[11] = mk(1, 8, 0, 0, 1,  0, 0, 0,        0, 0, 0,         0, 1, 0, 6, 'h66,     'h80,    0);
        tv[12] = mk(1, 10, 0, 0, 1, 0, 0, 0,        0, 0, 0,         0, 1, 0, 6, 'h66,     'h180,   0);
        tv[13] = mk(1, 11, 0, 0, 1, 0, 0, 0,        0, 0, 0,         0, 1, 0, 6, 'h66,     'h580,   0);
        tv[14] = mk(1, 12, 0, 0, 1, 0, 0, 0,        0, 0, 0,         0, 1, 0, 6, 'h66,     'hD80,   0);
        tv[15] = mk(0, 0, 0, 0, 0,  1, 10, 'hA10,   1, 7, 'hAAAA,    0, 1, 0, 6, 'h66,     'h1D80,  0);
        tv[16] = mk(0, 0, 0, 0, 0,  1, 11, 'hA11,   1, 8, 'hBBBB,    0, 1, 1, 10, 'hA10,   'h1D80,  0);
        tv[17] = mk(0, 0, 0, 0, 0,  1, 12, 'hA12,   0, 0, 0,         0, 0, 1, 11, 'hA11,   'h1980,  0);
        tv[18] = mk(0, 0, 0, 0, 0,  0, 0, 0,        0, 0, 0,         0, 0, 1, 12, 'hA12,   'h1180,  0);
        tv[19] = mk(0, 0, 0, 0, 0,  0, 0, 0,        0, 0, 0,         0, 1, 1, 7, 'hAAAA,   'h180,   0);
        tv[20] = mk(0, 0, 0, 0, 0,  0, 0, 0,        0, 0, 0,         0, 1, 1, 8, 'hBBBB,   'h100,   0);
        tv[21] = mk(0, 0, 0, 0, 0,  0, 0, 0,        0, 0, 0,         0, 1, 0, 8, 'hBBBB,   0,       0);
        tv[22] = mk(1, 3, 0, 0, 1,  0, 0, 0,        0, 0, 0,         0, 1, 0, 8, 'hBBBB,   0,       0);
        tv[23] = mk(1, 4, 0, 0, 1,  0, 0, 0,        0, 0, 0,         0, 1, 0, 8, 'hBBBB,   'h8,     0);
        tv[24] = mk(0, 0, 0, 0, 0,  0, 0, 0,        1, 4, 'h4444,    0, 1, 0, 8, 'hBBBB,   'h18,    0);
        tv[25] = mk(0, 0, 0, 0, 0,  1, 3, 'h3333,   0, 0, 0,         0, 1, 0, 8, 'hBBBB,   'h18,    0);
        tv[26] = mk(0, 0, 0, 0, 0,  0, 0, 0,        0, 0, 0,         0, 1, 1, 3, 'h3333,   'h18,    0);
        tv[27] = mk(0, 0, 0, 0, 0,  0, 0, 0,        0, 0, 0,         0, 1, 1, 4, 'h4444,   'h10,    0);
        tv[28] = mk(0, 0, 0, 0, 0,  0, 0, 0,        0, 0, 0,         0, 1, 0, 4, 'h4444,   0,       0);
        tv[29] = mk(0, 0, 0, 0, 0,  1, 9, 'h9999,   0, 0, 0,         0, 1, 0, 4, 'h4444,   0,       0);
        tv[30] = mk(0, 0, 0, 0, 0,  0, 0, 0,        0, 0, 0,         0, 1, 1, 9, 'h9999,   0,       1);
        tv[31] = mk(0, 0, 0, 0, 0,  0, 0, 0,        0, 0, 0,         0, 1, 0, 9, 'h9999,   0,       1);

        idle();
        repeat (2) @(negedge clk);
        chk("rst_busy", 0, busy, 0);
        chk("rst_we3", 0, 32'(we3), 0);
        chk("rst_a3", 0, 32'(a3), 0);
        chk("rst_wd3", 0, wd3, 0);
        chk("rst_err", 0, 32'(err_spurious), 0);
        rst = 1'b1;

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(tv[i]);
            #1;
            check_outputs(tv[i], i);
        end

        // mid-operation reset: busy = {7,8}, one LSU entry parked behind x0 ALU traffic
        @(negedge clk); drive(mk(1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,0,0,0,0,0,0));
        @(negedge clk); drive(mk(1, 8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,0,0,0,0,0,0));
        @(negedge clk); drive(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 7, 'h7777, 0,0,0,0,0,0,0));
        @(negedge clk); drive(mk(1, 8, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0,0,0,0,0,0,0));
        #1;
        chk("pre_rst_busy", 0, busy, 'h180);
        chk("pre_rst_waw_stall", 0, 32'(iss_stall), 1);
        chk("pre_rst_err", 0, 32'(err_spurious), 1);
        idle();
        #1 rst = 1'b0;
        #1;
        chk("async_busy", 0, busy, 0);
        chk("async_we3", 0, 32'(we3), 0);
        chk("async_a3", 0, 32'(a3), 0);
        chk("async_wd3", 0, wd3, 0);
        chk("async_err", 0, 32'(err_spurious), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_we3", i, 32'(we3), 0);
            chk("post_rst_l_ready", i, 32'(l_ready), 1);
            chk("post_rst_busy", i, busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
